// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Holds the FSM state encoding, the parity-mode values and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Unused upper bits of word must be zero so they do not disturb the result.
    function automatic logic parityBit(input logic [8:0] word, input int mode);
        return (mode == PAR_ODD) ? ~^word : ^word;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick in the last cycle of every CLK_DIV-cycle bit.
// clear holds the count at zero so the next bit starts a full period.
module uart_baud_tick #(
    parameter int CLK_DIV = 434
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk_in) begin
        if (rst || clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small inline write FIFO.
// Line, busy and finish are registered from the state, so they trail it by one cycle.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_in,
    input  logic                              rst,
    input  logic [DATA_BITS-1:0]              tx_data_in,
    input  logic                              tx_data_en,
    output logic                              tx_ready,
    output logic                              tx_busy,
    output logic                              tx_finish,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              tx_serial_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < PAR_NONE || PARITY > PAR_ODD ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badParam
        $error("uart_tx_cfg: parameter out of range");
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;

    uart_state_t          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BIT_W-1:0]     r_bitIdx;
    logic                 r_stopIdx;
    logic                 r_parity;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_finish;

    logic                 w_tick;
    logic                 w_clear;
    logic                 w_write;
    logic                 w_lastStop;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    assign tx_ready   = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_write    = tx_data_en && tx_ready;
    assign w_lastStop = (r_state == STOP) && w_tick && (r_stopIdx == (STOP_BITS == 2));
    assign w_pop      = (r_count != '0) && ((r_state == IDLE) || w_lastStop);
    assign w_head     = r_mem[r_rdPtr];
    // Every other state entry lands on a tick, where the counter wraps by itself.
    assign w_clear    = (r_state == IDLE);

    uart_baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk_in(clk_in),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_mem[r_wrPtr] <= tx_data_in;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bitIdx  <= '0;
            r_stopIdx <= 1'b0;
            r_parity  <= 1'b0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_finish  <= 1'b0;
        end else begin
            r_busy   <= (r_state != IDLE);
            r_finish <= w_lastStop;
            case (r_state)
                START:   r_txd <= 1'b0;
                DATA:    r_txd <= r_shift[0];
                PAR:     r_txd <= r_parity;
                default: r_txd <= 1'b1;
            endcase

            // A pop from the final stop cycle chains frames with no idle gap.
            if (w_pop) begin
                r_shift   <= w_head;
                r_parity  <= parityBit(9'(w_head), PARITY);
                r_bitIdx  <= '0;
                r_stopIdx <= 1'b0;
                r_state   <= START;
            end else if (w_tick) begin
                case (r_state)
                    START: begin
                        r_bitIdx <= '0;
                        r_state  <= DATA;
                    end
                    DATA: begin
                        r_shift <= r_shift >> 1;
                        if (r_bitIdx == BIT_W'(DATA_BITS - 1)) begin
                            r_stopIdx <= 1'b0;
                            r_state   <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end
                    PAR: begin
                        r_stopIdx <= 1'b0;
                        r_state   <= STOP;
                    end
                    STOP: begin
                        if (w_lastStop) begin
                            r_state <= IDLE;
                        end else begin
                            r_stopIdx <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign tx_serial_data = r_txd;
    assign tx_busy        = r_busy;
    assign tx_finish      = r_finish;
    assign fifo_count     = r_count;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 5N2) at CLK_DIV=4,
// compared cycle by cycle against a frame model built from the framing rules.
module tb_uart_tx_cfg;

    localparam int CLK_DIV = 4;
    localparam int NUM_DUT = 4;

    function automatic int cfgBits(input int i);
        return (i == 3) ? 5 : 8;
    endfunction

    function automatic int cfgParity(input int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    function automatic int cfgStop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic [7:0] dataIn [NUM_DUT];
    logic       dataEn [NUM_DUT];
    logic       ready  [NUM_DUT];
    logic       busy   [NUM_DUT];
    logic       finish [NUM_DUT];
    logic       serial [NUM_DUT];
    logic [2:0] count  [NUM_DUT];

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
        localparam int DB = cfgBits(g);
        uart_tx_cfg #(
            .CLK_DIV   (CLK_DIV),
            .DATA_BITS (DB),
            .PARITY    (cfgParity(g)),
            .STOP_BITS (cfgStop(g)),
            .FIFO_DEPTH(4)
        ) dut (
            .clk_in        (clk_in),
            .rst           (rst),
            .tx_data_in    (dataIn[g][DB-1:0]),
            .tx_data_en    (dataEn[g]),
            .tx_ready      (ready[g]),
            .tx_busy       (busy[g]),
            .tx_finish     (finish[g]),
            .fifo_count    (count[g]),
            .tx_serial_data(serial[g])
        );
    end

    // Reference frame: list of symbols from the framing rules, each stretched to CLK_DIV cycles.
    function automatic void expFrame(input int idx, input logic [7:0] word,
                                     output logic [255:0] bits, output int len);
        bit sym[$];
        int ones = 0;
        sym.push_back(1'b0);
        for (int i = 0; i < cfgBits(idx); i++) begin
            sym.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (cfgParity(idx) == 1) sym.push_back(ones % 2 == 1);
        if (cfgParity(idx) == 2) sym.push_back(ones % 2 == 0);
        for (int s = 0; s < cfgStop(idx); s++) sym.push_back(1'b1);
        bits = '1;
        len  = 0;
        foreach (sym[s]) begin
            for (int k = 0; k < CLK_DIV; k++) begin
                bits[len] = sym[s];
                len++;
            end
        end
    endfunction

    task automatic test_reset();
        logic [6:0] obs;
        rst       = 1'b1;
        dataIn[0] = 8'h5A;
        dataEn[0] = 1'b1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        for (int i = 0; i < NUM_DUT; i++) begin
            obs = {serial[i], busy[i], finish[i], count[i], ready[i]};
            checks++;
            if (obs !== 7'b1_0_0_000_1) begin
                errors++;
                $display("[TB] FAIL reset_state dut%0d: got %b, want %b", i, obs, 7'b1000001);
            end
        end
        @(posedge clk_in); #1;
        rst       = 1'b0;
        dataEn[0] = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({count[0], busy[0], serial[0]} !== 5'b000_0_1) begin
            errors++;
            $display("[TB] FAIL reset_write_ignored: got count=%0d busy=%b line=%b, want 0 0 1",
                     count[0], busy[0], serial[0]);
        end
    endtask

    task automatic test_frame(input int idx, input logic [7:0] word,
                              output logic [255:0] obsLine, output logic [255:0] obsFin);
        logic [255:0] fr, expLine, expBusy, expFin, obsBusy;
        int len;
        expFrame(idx, word, fr, len);
        expLine = '1;
        expBusy = '0;
        expFin  = '0;
        for (int i = 0; i < len; i++) begin
            expLine[2 + i] = fr[i];
            expBusy[2 + i] = 1'b1;
        end
        expFin[len + 1] = 1'b1;
        obsLine = '1;
        obsBusy = '0;
        obsFin  = '0;
        @(posedge clk_in); #1;
        dataIn[idx] = word;
        dataEn[idx] = 1'b1;
        @(posedge clk_in); #1;
        dataEn[idx] = 1'b0;
        @(negedge clk_in);
        checks++;
        if (count[idx] !== 3'd1) begin
            errors++;
            $display("[TB] FAIL frame_count dut%0d word %h: got %0d, want 1", idx, word, count[idx]);
        end
        for (int c = 0; c < len + 4; c++) begin
            if (c > 0) @(negedge clk_in);
            obsLine[c] = serial[idx];
            obsBusy[c] = busy[idx];
            obsFin[c]  = finish[idx];
        end
        checks++;
        if (obsLine !== expLine) begin
            errors++;
            $display("[TB] FAIL frame_line dut%0d word %h: got %h, want %h", idx, word, obsLine, expLine);
        end
        checks++;
        if (obsBusy !== expBusy) begin
            errors++;
            $display("[TB] FAIL frame_busy dut%0d word %h: got %h, want %h", idx, word, obsBusy, expBusy);
        end
        checks++;
        if (obsFin !== expFin) begin
            errors++;
            $display("[TB] FAIL frame_finish dut%0d word %h: got %h, want %h", idx, word, obsFin, expFin);
        end
    endtask

    task automatic test_8n1();
        logic [255:0] line, fin;
        test_frame(0, 8'h0E, line, fin);
        checks++;
        if (line[41:0] !== {40'hF0000FFF00, 2'b11}) begin
            errors++;
            $display("[TB] FAIL 8n1_0e_pattern: got %h, want %h", line[41:0], {40'hF0000FFF00, 2'b11});
        end
        checks++;
        if (fin[41] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL 8n1_finish_cycle40: got %b, want 1", fin[41]);
        end
    endtask

    task automatic test_parity();
        logic [255:0] line, fin;
        test_frame(1, 8'h0E, line, fin);
        checks++;
        if ({line[38], fin[45]} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL even_parity_bit: got bit=%b finish44=%b, want 1 1", line[38], fin[45]);
        end
        test_frame(2, 8'h0E, line, fin);
        checks++;
        if ({line[38], fin[45]} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL odd_parity_bit: got bit=%b finish44=%b, want 0 1", line[38], fin[45]);
        end
    endtask

    task automatic test_5n2();
        logic [255:0] line, fin;
        test_frame(3, 8'h1F, line, fin);
        checks++;
        if ({line[33:26], line[5:2], fin[33]} !== {8'hFF, 4'h0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL 5n2_stop_tail: got stops=%h start=%h finish32=%b, want ff 0 1",
                     line[33:26], line[5:2], fin[33]);
        end
    endtask

    task automatic test_random_frames();
        logic [255:0] line, fin;
        for (int i = 0; i < NUM_DUT; i++) begin
            repeat (3) test_frame(i, 8'($urandom), line, fin);
        end
    endtask

    task automatic test_back_to_back(input int idx);
        logic [7:0]   words [6];
        logic [5:0]   expReady, obsReady;
        logic [255:0] fr, expLine, expBusy, expFin, obsLine, obsBusy, obsFin;
        int len, occ, nCyc;
        occ = 0;
        for (int k = 0; k < 6; k++) begin
            words[k]    = 8'($urandom);
            expReady[k] = (occ != 4);
            if (expReady[k]) occ++;
            if (k == 1) occ--;
        end
        expLine = '1;
        expBusy = '0;
        expFin  = '0;
        len     = 0;
        for (int f = 0; f < 5; f++) begin
            expFrame(idx, words[f], fr, len);
            for (int i = 0; i < len; i++) begin
                expLine[2 + f * len + i] = fr[i];
                expBusy[2 + f * len + i] = 1'b1;
            end
            expFin[1 + (f + 1) * len] = 1'b1;
        end
        nCyc     = 5 * len + 4;
        obsLine  = '1;
        obsBusy  = '0;
        obsFin   = '0;
        obsReady = '0;
        for (int c = 0; c <= nCyc; c++) begin
            @(posedge clk_in); #1;
            dataEn[idx] = (c < 6);
            if (c < 6) dataIn[idx] = words[c];
            @(negedge clk_in);
            if (c < 6) obsReady[c] = ready[idx];
            if (c == 6) begin
                checks++;
                if (count[idx] !== 3'd4) begin
                    errors++;
                    $display("[TB] FAIL b2b_full_count dut%0d: got %0d, want 4", idx, count[idx]);
                end
            end
            if (c >= 1) begin
                obsLine[c - 1] = serial[idx];
                obsBusy[c - 1] = busy[idx];
                obsFin[c - 1]  = finish[idx];
            end
        end
        checks++;
        if (obsReady !== expReady) begin
            errors++;
            $display("[TB] FAIL b2b_ready dut%0d: got %b, want %b", idx, obsReady, expReady);
        end
        checks++;
        if (obsLine !== expLine) begin
            errors++;
            $display("[TB] FAIL b2b_line dut%0d: got %h, want %h", idx, obsLine, expLine);
        end
        checks++;
        if (obsBusy !== expBusy) begin
            errors++;
            $display("[TB] FAIL b2b_busy dut%0d: got %h, want %h", idx, obsBusy, expBusy);
        end
        checks++;
        if (obsFin !== expFin || $countones(obsFin) != 5) begin
            errors++;
            $display("[TB] FAIL b2b_finish dut%0d: got %h (%0d pulses), want %h (5 pulses)",
                     idx, obsFin, $countones(obsFin), expFin);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]   words [3];
        logic [255:0] fr, expLine, expBusy, obsLine, obsBusy, obsFin, line, fin;
        logic [6:0]   obs;
        int len;
        for (int k = 0; k < 3; k++) words[k] = 8'($urandom);
        expFrame(0, words[0], fr, len);
        expLine = '1;
        expBusy = '0;
        for (int i = 0; i < 18; i++) begin
            expLine[2 + i] = fr[i];
            expBusy[2 + i] = 1'b1;
        end
        obsLine = '1;
        obsBusy = '0;
        obsFin  = '0;
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk_in); #1;
            dataEn[0] = (c < 3);
            if (c < 3) dataIn[0] = words[c];
            rst = (c == 20);
            @(negedge clk_in);
            if (c == 19) begin
                checks++;
                if ({count[0], serial[0]} !== {3'd2, words[0][3]}) begin
                    errors++;
                    $display("[TB] FAIL midreset_pre: got count=%0d line=%b, want 2 %b",
                             count[0], serial[0], words[0][3]);
                end
            end
            if (c == 21) begin
                obs = {serial[0], busy[0], finish[0], count[0], ready[0]};
                checks++;
                if (obs !== 7'b1_0_0_000_1) begin
                    errors++;
                    $display("[TB] FAIL midreset_state: got %b, want %b", obs, 7'b1000001);
                end
            end
            if (c >= 1) begin
                obsLine[c - 1] = serial[0];
                obsBusy[c - 1] = busy[0];
                obsFin[c - 1]  = finish[0];
            end
        end
        checks++;
        if (obsLine !== expLine || obsBusy !== expBusy) begin
            errors++;
            $display("[TB] FAIL midreset_line: got line=%h busy=%h, want line=%h busy=%h",
                     obsLine, obsBusy, expLine, expBusy);
        end
        checks++;
        if (obsFin !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_no_finish: got %h, want 0", obsFin);
        end
        test_frame(0, 8'hA5, line, fin);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_DUT; i++) begin
            dataIn[i] = '0;
            dataEn[i] = 1'b0;
        end
        test_reset();
        test_8n1();
        test_parity();
        test_5n2();
        test_random_frames();
        test_back_to_back(0);
        test_back_to_back(3);
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk_in and rst.
REQ-002 The parameters SHALL be as follows:
- CLK_DIV, default 434: clk_in cycles per bit, minimum 2.
- DATA_BITS, default 8: data bits per frame, legal 5..9.
- PARITY, default 0: 0 none, 1 even, 2 odd.
- STOP_BITS, default 1: legal 1 or 2.
- FIFO_DEPTH, default 4: write-buffer depth, power of two, minimum 2.
REQ-003 The ports SHALL be as follows:
- clk_in  in  1: clock.
- rst  in  1: synchronous active-high reset.
- tx_data_in  in  DATA_BITS: word to send.
- tx_data_en  in  1: write strobe (valid).
- tx_ready  out  1: FIFO not full.
- tx_busy  out  1: a frame is on the line.
- tx_finish  out  1: one-cycle end-of-frame pulse.
- fifo_count  out  $clog2(FIFO_DEPTH+1): stored words.
- tx_serial_data  out  1: serial line, idle high.

Function
REQ-004 A word SHALL be written to the FIFO on a clk_in edge where tx_data_en=1 and tx_ready=1; tx_data_en while tx_ready=0 SHALL be ignored and the word dropped.
REQ-005 tx_ready SHALL equal (fifo_count != FIFO_DEPTH), combinationally from registered state.
REQ-006 The state machine SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-007 In IDLE with fifo_count>0, the block SHALL pop the head word into the shift register and enter START.
REQ-008 A word written into an empty FIFO while IDLE SHALL drive the line low exactly 2 cycles after the write edge.
REQ-009 Each bit SHALL be held for exactly CLK_DIV cycles.
- The bit counter SHALL clear on every state entry.
- The bit counter SHALL advance only in non-IDLE states.
REQ-010 The frame SHALL be sent in this order:
- Start bit 0.
- DATA_BITS data bits, LSB first.
- The parity bit, only if PARITY!=0: even makes total ones even; odd makes it odd.
- STOP_BITS stop bits of 1.
REQ-011 The parity bit SHALL be computed over the popped word and registered at pop time.
REQ-012 tx_finish SHALL pulse high in the last cycle of the final stop bit.
REQ-013 If the FIFO is non-empty in that final cycle, the block SHALL pop and enter START directly, so frames are back-to-back with zero idle cycles; otherwise it SHALL return to IDLE.
REQ-014 tx_busy SHALL be 1 in every state except IDLE.
REQ-015 A write and a pop in the same cycle SHALL leave fifo_count unchanged and corrupt no entry.
REQ-016 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 An out-of-range parameter SHALL cause an elaboration-time error.

Reset
REQ-018 While rst=1 at an edge, the block SHALL:
- set tx_serial_data=1, tx_busy=0, tx_finish=0 and fifo_count=0;
- set the state to IDLE;
- clear the bit counter, pointers and shift register.
REQ-019 Reset asserted mid-frame SHALL abandon the frame, drive the line high from the next cycle, discard FIFO contents and produce no tx_finish.
REQ-020 Writes presented during reset SHALL be ignored.

Structure
REQ-021 The package uart_pkg SHALL hold the state enum and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-022 Bit timing SHALL be a single sub-module, uart_baud_tick, with inputs clk_in, rst and clear and output tick, parameterised by CLK_DIV.
REQ-023 The FIFO SHALL be inline in uart_tx_cfg, with no extra sub-module.

Verification (all with CLK_DIV=4)
REQ-024 8N1, write 0x0E into an empty FIFO: line low at +2 cycles; data 0,1,1,1,0,0,0,0 at 4 cycles each; stop high 4 cycles; tx_finish at frame cycle 40; tx_busy high for 40 cycles.
REQ-025 PARITY=1 with 0x0E SHALL give parity bit 1; PARITY=2 SHALL give parity bit 0; frame length 44 cycles.
REQ-026 DATA_BITS=5, STOP_BITS=2, word 0x1F: frame of 32 cycles, last 8 cycles high, tx_finish at cycle 32.
REQ-027 FIFO_DEPTH=4, tx_data_en high for 6 consecutive cycles with words A..F:
- A..E accepted and F dropped, with tx_ready=0 on the 6th cycle;
- 5 contiguous frames sent with no idle gap;
- 5 tx_finish pulses.
REQ-028 rst asserted during data bit 3 with 2 words queued: line high next cycle, fifo_count=0, no tx_finish; after release, write 0xA5 gives a correct frame.
